// File: rtl/layer_sequencer.sv
// layer_sequencer: steps an MLP datapath through up to MAX_LAYERS layers, loading
// each layer's descriptor, pushing its four weight bytes and awaiting completion.
module layer_sequencer #(
    parameter int MAX_LAYERS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_wr_en,
    input  logic [$clog2(MAX_LAYERS)-1:0] cfg_wr_layer,
    input  logic [1:0]                    cfg_wr_addr,
    input  logic [31:0]                   cfg_wr_data,
    input  logic [3:0]                    num_layers,
    input  logic                          start,
    input  logic                          layer_complete,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [2:0]                    layer_idx,
    output logic                          wf_reset,
    output logic                          wf_push_col0,
    output logic                          wf_push_col1,
    output logic [7:0]                    wf_data_in,
    output logic                          start_mlp,
    output logic                          weights_ready,
    output logic signed [15:0]            norm_gain,
    output logic signed [31:0]            norm_bias,
    output logic [4:0]                    norm_shift,
    output logic signed [15:0]            q_inv_scale,
    output logic signed [7:0]             q_zero_point
);
    localparam int            LW      = $clog2(MAX_LAYERS);
    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [3:0]    MAX_L   = 4'(MAX_LAYERS);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_PUSH, S_ARM, S_WAIT_HI, S_WAIT_LO, S_NEXT, S_FINISH, S_ERROR
    } state_t;

    state_t               r_state, w_next;
    logic [31:0]          r_tab [MAX_LAYERS][4];
    logic [2:0]           r_layer_idx;
    logic [3:0]           r_eff;
    logic [3:0]           w_eff;
    logic                 r_err;
    logic [1:0]           r_push_cnt;
    logic [CW-1:0]        r_to_cnt;
    logic [31:0]          w_weights;
    logic signed [15:0]   r_norm_gain;
    logic signed [31:0]   r_norm_bias;
    logic [4:0]           r_norm_shift;
    logic signed [15:0]   r_q_inv_scale;
    logic signed [7:0]    r_q_zero_point;

    assign w_weights = r_tab[r_layer_idx[LW-1:0]][0];

    always_comb begin
        w_eff = num_layers;
        if (num_layers == 4'd0)
            w_eff = 4'd1;
        else if (num_layers > MAX_L)
            w_eff = MAX_L;
    end

    always_comb begin
        w_next        = r_state;
        busy          = 1'b1;
        done          = 1'b0;
        wf_reset      = 1'b0;
        wf_push_col0  = 1'b0;
        wf_push_col1  = 1'b0;
        wf_data_in    = 8'd0;
        start_mlp     = 1'b0;
        weights_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    w_next = S_CLR;
            end
            S_CLR: begin
                wf_reset = 1'b1;
                w_next   = S_PUSH;
            end
            S_PUSH: begin
                // bytes 0,1 go to column 0, bytes 2,3 to column 1
                wf_push_col0 = ~r_push_cnt[1];
                wf_push_col1 = r_push_cnt[1];
                wf_data_in   = w_weights[{r_push_cnt, 3'b000} +: 8];
                if (r_push_cnt == 2'd3)
                    w_next = S_ARM;
            end
            S_ARM: begin
                start_mlp     = 1'b1;
                weights_ready = 1'b1;
                w_next        = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (layer_complete)
                    w_next = S_WAIT_LO;
                else if (r_to_cnt == TO_LAST)
                    w_next = S_ERROR;
            end
            S_WAIT_LO: begin
                if (!layer_complete)
                    w_next = S_NEXT;
                else if (r_to_cnt == TO_LAST)
                    w_next = S_ERROR;
            end
            S_NEXT: begin
                if ({1'b0, r_layer_idx} == (r_eff - 4'd1))
                    w_next = S_FINISH;
                else
                    w_next = S_CLR;
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERROR: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_layer_idx    <= 3'd0;
            r_eff          <= 4'd0;
            r_err          <= 1'b0;
            r_push_cnt     <= 2'd0;
            r_to_cnt       <= '0;
            r_norm_gain    <= '0;
            r_norm_bias    <= '0;
            r_norm_shift   <= '0;
            r_q_inv_scale  <= '0;
            r_q_zero_point <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_eff       <= w_eff;
                r_err       <= 1'b0;
                r_layer_idx <= 3'd0;
            end
            if (r_state == S_ERROR)
                r_err <= 1'b1;
            if (r_state == S_NEXT && w_next == S_CLR)
                r_layer_idx <= r_layer_idx + 3'd1;
            r_push_cnt <= (r_state == S_PUSH) ? r_push_cnt + 2'd1 : 2'd0;
            // shared wait counter restarts on every state change
            if (w_next != r_state)
                r_to_cnt <= '0;
            else if (r_state == S_WAIT_HI || r_state == S_WAIT_LO)
                r_to_cnt <= r_to_cnt + CW'(1);
            if (r_state == S_CLR) begin
                r_norm_gain    <= r_tab[r_layer_idx[LW-1:0]][1][15:0];
                r_norm_shift   <= r_tab[r_layer_idx[LW-1:0]][1][20:16];
                r_norm_bias    <= r_tab[r_layer_idx[LW-1:0]][2];
                r_q_inv_scale  <= r_tab[r_layer_idx[LW-1:0]][3][15:0];
                r_q_zero_point <= r_tab[r_layer_idx[LW-1:0]][3][23:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LAYERS; i++)
                for (int j = 0; j < 4; j++)
                    r_tab[i][j] <= 32'd0;
        end else if (cfg_wr_en && r_state == S_IDLE) begin
            r_tab[cfg_wr_layer][cfg_wr_addr] <= cfg_wr_data;
        end
    end

    assign err          = r_err;
    assign layer_idx    = r_layer_idx;
    assign norm_gain    = r_norm_gain;
    assign norm_bias    = r_norm_bias;
    assign norm_shift   = r_norm_shift;
    assign q_inv_scale  = r_q_inv_scale;
    assign q_zero_point = r_q_zero_point;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed and randomized runs of layer_sequencer; a run-level
// reference model queues expected events that a negedge monitor consumes.
module tb_layer_sequencer;
    localparam int MAXL = 4;
    localparam int TMO  = 255;
    localparam int K_CLR = 0, K_PUSH = 1, K_ARM = 2, K_DONE = 3, K_END = 4;

    typedef struct packed {
        int           kind;
        logic [127:0] val;
    } evt_t;

    evt_t sb_q[$];

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_wr_en;
    logic [1:0]         cfg_wr_layer;
    logic [1:0]         cfg_wr_addr;
    logic [31:0]        cfg_wr_data;
    logic [3:0]         num_layers;
    logic               start;
    logic               layer_complete;
    logic               busy, done, err;
    logic [2:0]         layer_idx;
    logic               wf_reset, wf_push_col0, wf_push_col1;
    logic [7:0]         wf_data_in;
    logic               start_mlp, weights_ready;
    logic signed [15:0] norm_gain;
    logic signed [31:0] norm_bias;
    logic [4:0]         norm_shift;
    logic signed [15:0] q_inv_scale;
    logic signed [7:0]  q_zero_point;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_tab [MAXL][4];
    bit sb_off = 1'b0;

    layer_sequencer #(.MAX_LAYERS(MAXL), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_wr_layer(cfg_wr_layer),
        .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .num_layers(num_layers),
        .start(start), .layer_complete(layer_complete), .busy(busy), .done(done), .err(err),
        .layer_idx(layer_idx), .wf_reset(wf_reset), .wf_push_col0(wf_push_col0),
        .wf_push_col1(wf_push_col1), .wf_data_in(wf_data_in), .start_mlp(start_mlp),
        .weights_ready(weights_ready), .norm_gain(norm_gain), .norm_bias(norm_bias),
        .norm_shift(norm_shift), .q_inv_scale(q_inv_scale), .q_zero_point(q_zero_point)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: DUT event did not occur within its cycle bound", name);
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({busy, done, err, layer_idx, wf_reset, wf_push_col0, wf_push_col1,
                     wf_data_in, start_mlp, weights_ready, norm_gain, norm_bias,
                     norm_shift, q_inv_scale, q_zero_point});
    endfunction

    // Expected configuration/launch snapshot of layer l, taken from the model table.
    function automatic logic [127:0] arm_val(input int l);
        logic [31:0] w1, w2, w3;
        logic [2:0]  li;
        w1 = m_tab[l][1];
        w2 = m_tab[l][2];
        w3 = m_tab[l][3];
        li = 3'(l);
        return {47'd0, li, w1[15:0], w2, w1[20:16], w3[15:0], w3[23:16], 1'b1};
    endfunction

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   arm_cyc = 0;
    int   fall_cyc = -100;
    logic p_busy = 1'b0, p_lc = 1'b0, p_clr = 1'b0;
    logic signed [15:0] p_gain = 16'sd0;

    task automatic sb_check(input string name, input int kind, input logic [127:0] act);
        evt_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: unexpected event, got 0x%0h with nothing expected", name, act);
            return;
        end
        e = sb_q.pop_front();
        chk({name, "_kind"}, 128'(kind), 128'(e.kind));
        chk(name, act, e.val);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset && !sb_off) begin
            if (!busy)
                chk("idle_strobes", 128'({wf_reset, wf_push_col0, wf_push_col1, wf_data_in,
                                          start_mlp, weights_ready, done}), 128'd0);
            if (norm_gain != p_gain)
                chk("gain_change_after_clr", 128'(p_clr), 128'd1);
            if (wf_reset) begin
                sb_check("clr", K_CLR, 128'(layer_idx));
                if (layer_idx != 3'd0)
                    chk("clr_latency", 128'(cyc - fall_cyc), 128'd2);
            end
            if (wf_push_col0 || wf_push_col1)
                sb_check("push", K_PUSH, 128'({wf_push_col1, wf_push_col0, wf_data_in}));
            if (start_mlp) begin
                sb_check("arm", K_ARM, {47'd0, layer_idx, norm_gain, norm_bias, norm_shift,
                                        q_inv_scale, q_zero_point, weights_ready});
                arm_cyc = cyc;
            end
            if (done) begin
                sb_check("done", K_DONE, 128'd0);
                chk("done_latency", 128'(cyc - fall_cyc), 128'd2);
            end
            if (p_busy && !busy)
                sb_check("end", K_END, 128'({err, 32'(cyc - arm_cyc)}));
            if (p_lc && !layer_complete)
                fall_cyc = cyc;
        end
        p_busy = busy;
        p_lc   = layer_complete;
        p_clr  = wf_reset;
        p_gain = norm_gain;
    end

    // ---------------- stimulus ----------------
    task automatic wr(input int l, input int a, input logic [31:0] d);
        cfg_wr_layer = 2'(l);
        cfg_wr_addr  = 2'(a);
        cfg_wr_data  = d;
        cfg_wr_en    = 1'b1;
        @(posedge clk); #1;
        cfg_wr_en    = 1'b0;
        m_tab[l][a]  = d;
    endtask

    task automatic wait_arm(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (start_mlp) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("arm_wait");
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("idle_wait");
        @(posedge clk); #1;
    endtask

    // n: requested layers; tmo: never complete; mid: write+start while busy;
    // dfix/hfix: fixed completion delay/high time (negative/zero = random).
    task automatic run(input int n, input bit tmo, input bit mid, input int dfix, input int hfix);
        int eff;
        int dd[MAXL];
        int hh[MAXL];
        logic [31:0] w0;
        bit ok;
        eff = (n == 0) ? 1 : ((n > MAXL) ? MAXL : n);
        for (int l = 0; l < eff; l++) begin
            dd[l] = (dfix >= 0) ? dfix : int'($urandom_range(0, 20));
            hh[l] = (hfix > 0) ? hfix : int'($urandom_range(2, 12));
            w0 = m_tab[l][0];
            sb_q.push_back('{kind: K_CLR,  val: 128'(l)});
            sb_q.push_back('{kind: K_PUSH, val: 128'({2'b01, w0[7:0]})});
            sb_q.push_back('{kind: K_PUSH, val: 128'({2'b01, w0[15:8]})});
            sb_q.push_back('{kind: K_PUSH, val: 128'({2'b10, w0[23:16]})});
            sb_q.push_back('{kind: K_PUSH, val: 128'({2'b10, w0[31:24]})});
            sb_q.push_back('{kind: K_ARM,  val: arm_val(l)});
            if (tmo) break;
        end
        if (tmo) begin
            sb_q.push_back('{kind: K_END, val: 128'({1'b1, 32'(TMO + 2)})});
        end else begin
            sb_q.push_back('{kind: K_DONE, val: 128'd0});
            sb_q.push_back('{kind: K_END,  val: 128'({1'b0, 32'(dd[eff-1] + hh[eff-1] + 4)})});
        end
        num_layers = 4'(n);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        for (int l = 0; l < eff; l++) begin
            wait_arm(ok);
            if (!ok) begin
                @(posedge clk); #1;
                return;
            end
            if (tmo) break;
            @(posedge clk); #1;
            repeat (dd[l]) begin @(posedge clk); #1; end
            layer_complete = 1'b1;
            if (mid && l == 0) begin
                cfg_wr_layer = 2'd0;
                cfg_wr_addr  = 2'd1;
                cfg_wr_data  = 32'h001F_BEEF;
                cfg_wr_en    = 1'b1;
                num_layers   = 4'd1;
                start        = 1'b1;
            end
            @(posedge clk); #1;
            cfg_wr_en = 1'b0;
            start     = 1'b0;
            repeat (hh[l] - 1) begin @(posedge clk); #1; end
            layer_complete = 1'b0;
        end
        wait_idle(600);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        reset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_layer = 2'd0; cfg_wr_addr = 2'd0;
        cfg_wr_data = 32'd0; num_layers = 4'd0; start = 1'b0; layer_complete = 1'b0;
        for (int i = 0; i < MAXL; i++)
            for (int j = 0; j < 4; j++)
                m_tab[i][j] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 128'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_strobes", 128'({wf_reset, wf_push_col0, wf_push_col1, start_mlp}), 128'd0);
        @(posedge clk); #1;

        // single layer, completion 6 cycles after ARM, high 9 cycles
        wr(0, 0, 32'h0403_0201);
        run(1, 1'b0, 1'b0, 5, 9);

        // three layers with distinct gains
        wr(0, 1, 32'h0003_0100); wr(1, 1, 32'h0005_0200); wr(2, 1, 32'h0007_0300);
        wr(1, 0, 32'h1122_3344); wr(2, 0, 32'hF0E0_D0C0);
        wr(1, 2, 32'h8000_0001); wr(2, 3, 32'h00FF_8000);
        run(3, 1'b0, 1'b0, -1, 0);

        // timeout, then the next start clears err
        run(1, 1'b1, 1'b0, -1, 0);
        chk("err_sticky", 128'({err, busy}), 128'b10);
        run(2, 1'b0, 1'b0, -1, 0);

        // layer-count clamping
        run(0, 1'b0, 1'b0, -1, 0);
        run(9, 1'b0, 1'b0, -1, 0);

        // write and start while busy are ignored; readback via a later run
        run(2, 1'b0, 1'b1, -1, 0);
        run(1, 1'b0, 1'b0, -1, 0);

        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 4; w++)
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom());
            run(int'($urandom_range(0, 15)), 1'b0, 1'b0, -1, 0);
        end

        // reset in the third push cycle
        sb_off = 1'b1;
        wr(0, 0, 32'hA1B2_C3D4);
        num_layers = 4'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("clr_strobe", 128'(wf_reset), 128'd1);
        repeat (3) begin @(posedge clk); #1; end
        chk("push2_pre_reset", 128'({wf_push_col1, wf_push_col0, wf_data_in}), 128'({2'b10, 8'hB2}));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("reset_mid_push", all_outs(), 128'd0);
        @(posedge clk); #1;
        chk("no_push_after_reset", 128'({wf_reset, wf_push_col0, wf_push_col1, start_mlp, busy}), 128'd0);
        for (int i = 0; i < MAXL; i++)
            for (int j = 0; j < 4; j++)
                m_tab[i][j] = 32'd0;
        sb_off = 1'b0;
        run(4, 1'b0, 1'b0, -1, 0);

        repeat (3) begin @(posedge clk); #1; end
        chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
